hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard.sv | 121 ++++++++++++
 tb/tb_hazard_scoreboard.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Register hazard scoreboard for an in-order pipeline.
// One 3-bit pending counter per integer register (x1..x31) and per FP register (f0..f31).
// It stalls the ID stage on RAW hazards and on WAW hazards where an older write would
// land after the new one. A counter loads the result latency at issue and then counts
// down to zero, at which point the value can be forwarded.
module hazard_scoreboard (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ID_valid,
  input  logic       ID_use_rs1,
  input  logic       ID_use_rs2,
  input  logic       ID_use_frs1,
  input  logic       ID_use_frs2,
  input  logic [4:0] ID_rs1,
  input  logic [4:0] ID_rs2,
  input  logic [4:0] ID_rd,
  input  logic       ID_wr_rd,
  input  logic       ID_wr_frd,
  input  logic [2:0] ID_lat,
  input  logic       flush,
  input  logic       freeze,
  output logic       ID_stall,
  output logic       sb_idle
);

  localparam int unsigned NumRegs = 32;
  localparam int unsigned CntW    = 3;

  typedef logic [CntW-1:0] cnt_t;

  cnt_t icnt_q [NumRegs];
  cnt_t icnt_d [NumRegs];
  cnt_t fcnt_q [NumRegs];
  cnt_t fcnt_d [NumRegs];

  // Counter values at the source and destination indices.
  cnt_t icnt_rs1, icnt_rs2, icnt_rd;
  cnt_t fcnt_rs1, fcnt_rs2, fcnt_rd;

  logic rs1_nz, rs2_nz, rd_nz, lat_nz;
  logic raw_i, raw_f, waw_i, waw_f;
  logic issue, load_i, load_f;
  logic any_pending;

  assign icnt_rs1 = icnt_q[ID_rs1];
  assign icnt_rs2 = icnt_q[ID_rs2];
  assign icnt_rd  = icnt_q[ID_rd];
  assign fcnt_rs1 = fcnt_q[ID_rs1];
  assign fcnt_rs2 = fcnt_q[ID_rs2];
  assign fcnt_rd  = fcnt_q[ID_rd];

  assign rs1_nz = (ID_rs1 != 5'd0);
  assign rs2_nz = (ID_rs2 != 5'd0);
  assign rd_nz  = (ID_rd != 5'd0);
  assign lat_nz = (ID_lat != 3'd0);

  // Hazard detection and issue qualification; the stall is independent of freeze.
  always_comb begin
    raw_i = (ID_use_rs1 & rs1_nz & (icnt_rs1 != '0)) |
            (ID_use_rs2 & rs2_nz & (icnt_rs2 != '0));
    raw_f = (ID_use_frs1 & (fcnt_rs1 != '0)) |
            (ID_use_frs2 & (fcnt_rs2 != '0));
    // The new write may issue if the older one lands no later than it does.
    waw_i = ID_wr_rd & rd_nz & (icnt_rd > ID_lat);
    waw_f = ID_wr_frd & (fcnt_rd > ID_lat);

    ID_stall = ID_valid & ~flush & (raw_i | raw_f | waw_i | waw_f);
    issue    = ID_valid & ~ID_stall & ~flush & ~freeze;

    // A dual-write instruction only updates the FP file.
    load_f = issue & ID_wr_frd & lat_nz;
    load_i = issue & ID_wr_rd & ~ID_wr_frd & rd_nz & lat_nz;
  end

  // Next-state counters: a load takes priority over the decrement, and freeze holds everything.
  always_comb begin
    for (int i = 0; i < NumRegs; i++) begin
      icnt_d[i] = icnt_q[i];
      fcnt_d[i] = fcnt_q[i];
      if (!freeze) begin
        if (load_i && (ID_rd == 5'(i))) begin
          icnt_d[i] = ID_lat;
        end else if (icnt_q[i] != '0) begin
          icnt_d[i] = icnt_q[i] - 3'd1;
        end
        if (load_f && (ID_rd == 5'(i))) begin
          fcnt_d[i] = ID_lat;
        end else if (fcnt_q[i] != '0) begin
          fcnt_d[i] = fcnt_q[i] - 3'd1;
        end
      end
    end
    // x0 is hardwired and never pending.
    icnt_d[0] = '0;
  end

  // Counter state; reset discards every pending entry immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NumRegs; i++) begin
        icnt_q[i] <= '0;
        fcnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NumRegs; i++) begin
        icnt_q[i] <= icnt_d[i];
        fcnt_q[i] <= fcnt_d[i];
      end
    end
  end

  // Idle when no tracked counter holds a pending result.
  always_comb begin
    any_pending = 1'b0;
    for (int i = 0; i < NumRegs; i++) begin
      any_pending = any_pending | (|icnt_q[i]) | (|fcnt_q[i]);
    end
    sb_idle = ~any_pending;
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard. The reference model records, for each register,
// the "virtual time" at which its result becomes forwardable. Virtual time advances only on
// unfrozen cycles, so the remaining latency is the difference between that time and now.
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ID_valid, ID_use_rs1, ID_use_rs2, ID_use_frs1, ID_use_frs2;
  logic [4:0] ID_rs1, ID_rs2, ID_rd;
  logic       ID_wr_rd, ID_wr_frd;
  logic [2:0] ID_lat;
  logic       flush, freeze;
  logic       ID_stall, sb_idle;

  int n_cmp  = 0;
  int n_fail = 0;

  int ready_i [32];
  int ready_f [32];
  int vt;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ID_valid   (ID_valid),
    .ID_use_rs1 (ID_use_rs1),
    .ID_use_rs2 (ID_use_rs2),
    .ID_use_frs1(ID_use_frs1),
    .ID_use_frs2(ID_use_frs2),
    .ID_rs1     (ID_rs1),
    .ID_rs2     (ID_rs2),
    .ID_rd      (ID_rd),
    .ID_wr_rd   (ID_wr_rd),
    .ID_wr_frd  (ID_wr_frd),
    .ID_lat     (ID_lat),
    .flush      (flush),
    .freeze     (freeze),
    .ID_stall   (ID_stall),
    .sb_idle    (sb_idle)
  );

  function automatic int rem_i(input logic [4:0] r);
    if (r == 5'd0) return 0;
    return (ready_i[r] > vt) ? ready_i[r] - vt : 0;
  endfunction

  function automatic int rem_f(input logic [4:0] r);
    return (ready_f[r] > vt) ? ready_f[r] - vt : 0;
  endfunction

  function automatic logic model_stall();
    logic haz;
    haz = (ID_use_rs1 && rem_i(ID_rs1) != 0) || (ID_use_rs2 && rem_i(ID_rs2) != 0) ||
          (ID_use_frs1 && rem_f(ID_rs1) != 0) || (ID_use_frs2 && rem_f(ID_rs2) != 0) ||
          (ID_wr_rd && rem_i(ID_rd) > int'(ID_lat)) ||
          (ID_wr_frd && rem_f(ID_rd) > int'(ID_lat));
    return ID_valid && !flush && haz;
  endfunction

  function automatic logic model_idle();
    for (int i = 0; i < 32; i++) begin
      if (rem_i(5'(i)) != 0 || rem_f(5'(i)) != 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_reset();
    vt = 0;
    for (int i = 0; i < 32; i++) begin
      ready_i[i] = 0;
      ready_f[i] = 0;
    end
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic clear_in();
    ID_valid = 0; ID_use_rs1 = 0; ID_use_rs2 = 0; ID_use_frs1 = 0; ID_use_frs2 = 0;
    ID_rs1 = 0; ID_rs2 = 0; ID_rd = 0; ID_wr_rd = 0; ID_wr_frd = 0; ID_lat = 0;
    flush = 0; freeze = 0;
  endtask

  // Let combinational outputs settle, then compare them with the model.
  task automatic settle(input string tag);
    #2;
    check({tag, "/stall"}, ID_stall, model_stall());
    check({tag, "/idle"}, sb_idle, model_idle());
  endtask

  // Advance one clock edge and apply the same edge to the model.
  task automatic tick();
    logic iss;
    iss = ID_valid && !model_stall() && !flush && !freeze;
    @(posedge clk);
    if (!freeze) vt++;
    if (iss && ID_lat != 3'd0) begin
      if (ID_wr_frd) ready_f[ID_rd] = vt + int'(ID_lat);
      else if (ID_wr_rd && ID_rd != 5'd0) ready_i[ID_rd] = vt + int'(ID_lat);
    end
    #1;
  endtask

  task automatic issue_int(input logic [4:0] rd, input logic [2:0] lat);
    clear_in();
    ID_valid = 1; ID_wr_rd = 1; ID_rd = rd; ID_lat = lat;
    settle("issue_int");
    tick();
  endtask

  task automatic issue_fp(input logic [4:0] rd, input logic [2:0] lat);
    clear_in();
    ID_valid = 1; ID_wr_frd = 1; ID_rd = rd; ID_lat = lat;
    settle("issue_fp");
    tick();
  endtask

  task automatic drain(input int n);
    clear_in();
    for (int i = 0; i < n; i++) begin
      settle("drain");
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    clear_in();
    rst_n = 1'b0;
    #1;
    check("rst_idle", sb_idle, 1'b1);
    ID_valid = 1; ID_use_rs1 = 1; ID_rs1 = 5'd3; ID_use_frs2 = 1; ID_rs2 = 5'd3;
    ID_wr_rd = 1; ID_rd = 5'd3; ID_lat = 3'd0;
    #1;
    check("rst_stall", ID_stall, 1'b0);
    clear_in();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    settle("post_rst");

    // Load-use: lat=2 gives two stall cycles, then the reader issues.
    issue_int(5'd5, 3'd2);
    clear_in();
    ID_valid = 1; ID_use_rs1 = 1; ID_rs1 = 5'd5;
    settle("lu0"); check("lu_stall0", ID_stall, 1'b1); tick();
    settle("lu1"); check("lu_stall1", ID_stall, 1'b1); tick();
    settle("lu2"); check("lu_stall2", ID_stall, 1'b0); tick();
    drain(2);

    // x0 is never tracked; an x7 write does not stall an f7 reader.
    issue_int(5'd0, 3'd3);
    settle("x0"); check("x0_idle", sb_idle, 1'b1);
    issue_int(5'd7, 3'd3);
    clear_in();
    ID_valid = 1; ID_use_frs1 = 1; ID_rs1 = 5'd7;
    settle("xf"); check("xfile_stall", ID_stall, 1'b0); check("xfile_busy", sb_idle, 1'b0);
    tick();
    drain(8);

    // Freeze holds fcnt[3]=2 for four cycles; after release the stall lasts two more.
    issue_fp(5'd3, 3'd2);
    clear_in();
    ID_valid = 1; ID_use_frs1 = 1; ID_rs1 = 5'd3; freeze = 1;
    for (int i = 0; i < 4; i++) begin
      settle("frz"); check("frz_stall", ID_stall, 1'b1); tick();
    end
    freeze = 0;
    settle("frz_r0"); check("frz_rel0", ID_stall, 1'b1); tick();
    settle("frz_r1"); check("frz_rel1", ID_stall, 1'b1); tick();
    settle("frz_r2"); check("frz_rel2", ID_stall, 1'b0); tick();
    drain(2);

    // WAW: icnt[9]=1 then a lat=4 write issues and reloads to 4.
    issue_int(5'd9, 3'd2);
    drain(1);
    clear_in();
    ID_valid = 1; ID_wr_rd = 1; ID_rd = 5'd9; ID_lat = 3'd4;
    settle("waw_a"); check("waw_load_ok", ID_stall, 1'b0); tick();
    ID_lat = 3'd3;
    settle("waw_b"); check("waw_is4", ID_stall, 1'b1); tick();
    settle("waw_c"); check("waw_is3", ID_stall, 1'b0); tick();
    // icnt[9]=3 now; load 5, then a lat=2 writer waits until icnt[9]<=2.
    issue_int(5'd9, 3'd5);
    clear_in();
    ID_valid = 1; ID_wr_rd = 1; ID_rd = 5'd9; ID_lat = 3'd2;
    for (int i = 0; i < 3; i++) begin
      settle("waw_d"); check("waw_hi", ID_stall, 1'b1); tick();
    end
    settle("waw_e"); check("waw_le2", ID_stall, 1'b0); tick();
    drain(4);

    // Flush: no stall, no load, and older entries keep counting down.
    issue_int(5'd4, 3'd3);
    clear_in();
    ID_valid = 1; ID_use_rs1 = 1; ID_rs1 = 5'd4; ID_wr_rd = 1; ID_rd = 5'd10;
    ID_lat = 3'd5; flush = 1;
    settle("fl0"); check("flush_stall", ID_stall, 1'b0); tick();
    clear_in();
    ID_valid = 1; ID_use_rs1 = 1; ID_rs1 = 5'd10; ID_wr_rd = 1; ID_rd = 5'd4; ID_lat = 3'd2;
    settle("fl1"); check("flush_noload", ID_stall, 1'b0); tick();
    drain(4);

    // Async reset between edges discards pending state immediately.
    issue_int(5'd12, 3'd6);
    clear_in();
    #1;
    check("ar_busy", sb_idle, 1'b0);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("ar_idle", sb_idle, 1'b1);
    rst_n = 1'b1;
    ID_valid = 1; ID_use_rs1 = 1; ID_rs1 = 5'd12;
    #1;
    check("ar_nostall", ID_stall, 1'b0);
    @(posedge clk);
    #1;
    if (!freeze) vt++;

    // Random phase: small register window to provoke hazards.
    for (int n = 0; n < 600; n++) begin
      ID_valid    = ($urandom_range(0, 3) != 0);
      ID_use_rs1  = $urandom_range(0, 1);
      ID_use_rs2  = $urandom_range(0, 1);
      ID_use_frs1 = ($urandom_range(0, 3) == 0);
      ID_use_frs2 = ($urandom_range(0, 3) == 0);
      ID_rs1      = 5'($urandom_range(0, 7));
      ID_rs2      = 5'($urandom_range(0, 7));
      ID_rd       = 5'($urandom_range(0, 7));
      ID_wr_rd    = $urandom_range(0, 1);
      ID_wr_frd   = ($urandom_range(0, 3) == 0);
      ID_lat      = 3'($urandom_range(0, 7));
      flush       = ($urandom_range(0, 7) == 0);
      freeze      = ($urandom_range(0, 7) == 0);
      settle("rnd");
      if ($urandom_range(0, 99) == 0) begin
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rnd_rst_idle", sb_idle, 1'b1);
        rst_n = 1'b1;
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
